// File: rtl/deadlock_df_monitor.sv
// deadlock_df_monitor
//   Dataflow deadlock monitor for one HLS dataflow region. A deadlock is
//   "confirmed" once every process is stopped, at least one of them is
//   stopped on an AXI-Stream channel, and that condition has held for
//   HOLD_CYCLES consecutive cycles. The child_block input chains in the
//   monitor of a nested region (tie 1 when there is none).
//
//   Optional feature macro: DEADLOCK_MON_SNAPSHOT_EN
//     defined   -> snap_axis/snap_stop capture the stream/process state at the
//                  first confirmed deadlock after reset/clear
//     undefined -> snap_axis/snap_stop are constant 0
//
// Ports
//   clock, reset       clock; synchronous active-high reset
//   clear              sync clear of sticky flag, event counter, snapshots
//   axis_block_sigs    [NAXIS] per-channel stream blocked
//   inst_idle_sigs     [NPROC] per-process idle
//   inst_block_sigs    [NPROC] per-process blocked on internal channel
//   child_block        block output of nested-region monitor
//   block              deadlock currently confirmed (registered)
//   block_latched      sticky: a deadlock was confirmed since reset/clear
//   axis_block_info    [NAXIS] registered stream-blocked sigs, gated by block
//   event_count        [CNT_W] saturating count of deadlock entries
//   snap_axis          [NAXIS] snapshot of axis_block_sigs at entry
//   snap_stop          [NPROC] snapshot of inst_block_sigs at entry
module deadlock_df_monitor #(
  parameter int               NPROC          = 3,
  parameter int               NAXIS          = 2,
  parameter logic [NPROC-1:0] AXIS_PROC_MASK = 3'b010,
  parameter int               HOLD_CYCLES    = 4,
  parameter int               CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [NAXIS-1:0] axis_block_sigs,
  input  logic [NPROC-1:0] inst_idle_sigs,
  input  logic [NPROC-1:0] inst_block_sigs,
  input  logic             child_block,
  output logic             block,
  output logic             block_latched,
  output logic [NAXIS-1:0] axis_block_info,
  output logic [CNT_W-1:0] event_count,
  output logic [NAXIS-1:0] snap_axis,
  output logic [NPROC-1:0] snap_stop
);

  // The hold counter must be able to reach HOLD_CYCLES-1.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W)) begin : g_bad_hold
    $error("deadlock_df_monitor: HOLD_CYCLES must be in [1, 2**CNT_W-1]");
  end

  typedef enum logic [1:0] {MON_IDLE, MON_COUNT, MON_BLOCK} mon_state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam bit               HOLD_ONE  = (HOLD_CYCLES == 1);

  mon_state_t       r_state;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_block;
  logic             r_latched;
  logic [CNT_W-1:0] r_cnt;
  logic [NAXIS-1:0] r_axis;

  logic [NPROC-1:0] w_pab;
  logic [NPROC-1:0] w_stop;
  logic             w_cond;
  logic             w_entry;

  // A process counts as AXIS-blocked only when the nested region is also
  // deadlocked, so a child that is still running never trips this monitor.
  assign w_pab  = AXIS_PROC_MASK & {NPROC{child_block & (|axis_block_sigs)}};
  assign w_stop = inst_idle_sigs | inst_block_sigs | w_pab;
  assign w_cond = (|w_pab) & (&w_stop);

  // Edge into MON_BLOCK; drives the sticky flag, counter and snapshot.
  assign w_entry = w_cond &&
                   ((r_state == MON_IDLE  && HOLD_ONE) ||
                    (r_state == MON_COUNT && r_hcnt == HOLD_LAST));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= MON_IDLE;
      r_hcnt    <= '0;
      r_block   <= 1'b0;
      r_latched <= 1'b0;
      r_cnt     <= '0;
      r_axis    <= '0;
    end else begin
      r_axis <= axis_block_sigs;

      case (r_state)
        MON_IDLE: begin
          if (w_cond) begin
            if (HOLD_ONE) begin
              r_state <= MON_BLOCK;
              r_block <= 1'b1;
            end else begin
              r_state <= MON_COUNT;
              r_hcnt  <= CNT_W'(1);
            end
          end
        end
        MON_COUNT: begin
          if (!w_cond) begin
            // Any gap restarts the hold window from scratch.
            r_state <= MON_IDLE;
            r_hcnt  <= '0;
          end else if (r_hcnt == HOLD_LAST) begin
            r_state <= MON_BLOCK;
            r_block <= 1'b1;
            r_hcnt  <= '0;
          end else begin
            r_hcnt <= r_hcnt + CNT_W'(1);
          end
        end
        MON_BLOCK: begin
          if (!w_cond) begin
            r_state <= MON_IDLE;
            r_block <= 1'b0;
          end
        end
        default: begin
          r_state <= MON_IDLE;
          r_block <= 1'b0;
          r_hcnt  <= '0;
        end
      endcase

      // Entry beats a coincident clear: the new event is the first one.
      if (w_entry) begin
        r_latched <= 1'b1;
        if (clear)              r_cnt <= CNT_W'(1);
        else if (r_cnt != '1)   r_cnt <= r_cnt + CNT_W'(1);
      end else if (clear) begin
        r_latched <= 1'b0;
        r_cnt     <= '0;
      end
    end
  end

  assign block           = r_block;
  assign block_latched   = r_latched;
  assign event_count     = r_cnt;
  assign axis_block_info = r_axis & {NAXIS{r_block}};

`ifdef DEADLOCK_MON_SNAPSHOT_EN
  logic [NAXIS-1:0] r_snap_axis;
  logic [NPROC-1:0] r_snap_stop;

  // Only the first entry since reset/clear is captured; r_latched marks that
  // a capture already happened, and a same-cycle clear re-arms it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_snap_axis <= '0;
      r_snap_stop <= '0;
    end else if (w_entry && (!r_latched || clear)) begin
      r_snap_axis <= axis_block_sigs;
      r_snap_stop <= inst_block_sigs;
    end else if (clear) begin
      r_snap_axis <= '0;
      r_snap_stop <= '0;
    end
  end

  assign snap_axis = r_snap_axis;
  assign snap_stop = r_snap_stop;
`else
  assign snap_axis = '0;
  assign snap_stop = '0;
`endif

endmodule

// File: tb/tb_deadlock_df_monitor.sv
module tb_deadlock_df_monitor;
  localparam int NP = 3;
  localparam int NA = 2;
  localparam int H1 = 4;   // default instance
  localparam int H2 = 2;   // small-counter instance
  localparam int CW2 = 2;
  localparam logic [NP-1:0] MASK = 3'b010;
`ifdef DEADLOCK_MON_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, clear, child_block;
  logic [NA-1:0] axis_block_sigs;
  logic [NP-1:0] inst_idle_sigs, inst_block_sigs;

  logic          block, block_latched;
  logic [NA-1:0] axis_block_info, snap_axis;
  logic [7:0]    event_count;
  logic [NP-1:0] snap_stop;

  logic           b2_block, b2_latched;
  logic [NA-1:0]  b2_info, b2_snap_axis;
  logic [CW2-1:0] b2_count;
  logic [NP-1:0]  b2_snap_stop;

  deadlock_df_monitor u_dut (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .child_block(child_block),
    .block(block), .block_latched(block_latched),
    .axis_block_info(axis_block_info), .event_count(event_count),
    .snap_axis(snap_axis), .snap_stop(snap_stop));

  deadlock_df_monitor #(.HOLD_CYCLES(H2), .CNT_W(CW2)) u_dut2 (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .child_block(child_block),
    .block(b2_block), .block_latched(b2_latched),
    .axis_block_info(b2_info), .event_count(b2_count),
    .snap_axis(b2_snap_axis), .snap_stop(b2_snap_stop));

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: a deadlock is confirmed while the condition has held
  // for at least H consecutive sampled edges.
  int            m_run, m2_run;
  bit            m_blk, m2_blk, m_lat, m2_lat, m_have;
  int            m_cnt, m2_cnt;
  logic [NA-1:0] m_axr, m_sa;
  logic [NP-1:0] m_ss;

  task automatic model_edge();
    bit          any_axis, cond, nb, nb2, ent, ent2;
    logic [NP-1:0] pab;
    any_axis = |axis_block_sigs;
    pab  = MASK & {NP{child_block & any_axis}};
    cond = (|pab) && (&(inst_idle_sigs | inst_block_sigs | pab));
    if (reset) begin
      m_run = 0; m2_run = 0; m_blk = 0; m2_blk = 0; m_lat = 0; m2_lat = 0;
      m_cnt = 0; m2_cnt = 0; m_have = 0; m_axr = '0; m_sa = '0; m_ss = '0;
      return;
    end
    m_run  = cond ? m_run + 1 : 0;
    m2_run = cond ? m2_run + 1 : 0;
    nb  = (m_run >= H1);
    nb2 = (m2_run >= H2);
    ent  = nb && !m_blk;
    ent2 = nb2 && !m2_blk;
    m_blk = nb; m2_blk = nb2;
    m_axr = axis_block_sigs;
    if (clear) begin
      m_lat = 0; m_cnt = 0; m_have = 0; m_sa = '0; m_ss = '0;
      m2_lat = 0; m2_cnt = 0;
    end
    if (ent) begin
      m_lat = 1;
      if (m_cnt < 255) m_cnt++;
      if (!m_have) begin
        m_have = 1; m_sa = axis_block_sigs; m_ss = inst_block_sigs;
      end
    end
    if (ent2) begin
      m2_lat = 1;
      if (m2_cnt < 3) m2_cnt++;
    end
  endtask

  task automatic check_all();
    chk("block", block, m_blk);
    chk("block_latched", block_latched, m_lat);
    chk("axis_block_info", axis_block_info, m_blk ? m_axr : '0);
    chk("event_count", event_count, m_cnt);
    chk("snap_axis", snap_axis, SNAP ? m_sa : '0);
    chk("snap_stop", snap_stop, SNAP ? m_ss : '0);
    chk("b2_block", b2_block, m2_blk);
    chk("b2_latched", b2_latched, m2_lat);
    chk("b2_count", b2_count, m2_cnt);
  endtask

  task automatic drive(input logic [NP-1:0] idl, input logic [NP-1:0] blk,
                       input logic [NA-1:0] ax, input logic ch, input logic clr);
    @(negedge clock);
    inst_idle_sigs = idl; inst_block_sigs = blk; axis_block_sigs = ax;
    child_block = ch; clear = clr;
    @(posedge clock);
    model_edge();
    #1 check_all();
  endtask

  // Deadlocked pattern held n cycles, then released for one cycle.
  task automatic dl_pulse(input int n);
    for (int i = 0; i < n; i++) drive(3'b101, 3'b000, 2'b01, 1'b1, 1'b0);
    drive(3'b000, 3'b000, 2'b01, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; child_block = 1'b1;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
    drive('0, '0, '0, 1'b1, 1'b0);
    drive(3'b111, 3'b111, 2'b11, 1'b1, 1'b1);
    reset = 1'b0;

    // Basic confirmation after HOLD_CYCLES.
    for (int i = 0; i < 3; i++) drive(3'b101, 3'b000, 2'b01, 1'b1, 1'b0);
    chk("tp1_not_yet", block, 1'b0);
    drive(3'b101, 3'b000, 2'b01, 1'b1, 1'b0);
    chk("tp1_block", block, 1'b1);
    chk("tp1_info", axis_block_info, 2'b01);
    chk("tp1_count", event_count, 8'd1);
    drive('0, '0, '0, 1'b1, 1'b0);

    // One-cycle drop restarts the window.
    for (int i = 0; i < 3; i++) drive(3'b101, 3'b000, 2'b01, 1'b1, 1'b0);
    drive('0, '0, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(3'b101, 3'b000, 2'b01, 1'b1, 1'b0);
    chk("tp2_not_yet", block, 1'b0);
    drive(3'b101, 3'b000, 2'b01, 1'b1, 1'b0);
    chk("tp2_block", block, 1'b1);
    drive('0, '0, '0, 1'b1, 1'b1);

    // Child not deadlocked: never confirms.
    for (int i = 0; i < 12; i++) drive(3'b111, 3'b111, 2'b11, 1'b0, 1'b0);
    chk("tp3_count", event_count, 8'd0);

    // Repeated entries, saturation of the small counter, clear.
    for (int i = 0; i < 3; i++) dl_pulse(H1);
    chk("tp4_count3", event_count, 8'd3);
    chk("tp4_latched", block_latched, 1'b1);
    for (int i = 0; i < 2; i++) dl_pulse(H1);
    chk("tp5_sat", b2_count, 2'd3);
    drive('0, '0, '0, 1'b1, 1'b1);
    chk("tp4_clr_lat", block_latched, 1'b0);
    chk("tp4_clr_cnt", event_count, 8'd0);

    // Snapshot keeps the first entry only.
    for (int i = 0; i < H1; i++) drive(3'b010, 3'b101, 2'b10, 1'b1, 1'b0);
    drive('0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < H1; i++) drive(3'b111, 3'b011, 2'b01, 1'b1, 1'b0);
    chk("tp6_snap_stop", snap_stop, SNAP ? 3'b101 : 3'b000);
    chk("tp6_snap_axis", snap_axis, SNAP ? 2'b10 : 2'b00);

    // Clear coincident with entry: entry wins.
    drive('0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < H1 - 1; i++) drive(3'b101, 3'b000, 2'b11, 1'b1, 1'b0);
    drive(3'b101, 3'b010, 2'b11, 1'b1, 1'b1);
    chk("clr_entry_cnt", event_count, 8'd1);
    chk("clr_entry_lat", block_latched, 1'b1);

    // Randomized segments biased toward deadlock patterns.
    for (int seg = 0; seg < 600; seg++) begin
      int len = $urandom_range(1, 7);
      bit dl  = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        logic [NP-1:0] idl, blk;
        logic [NA-1:0] ax;
        logic ch, clr;
        reset = ($urandom_range(0, 299) == 0);
        clr = ($urandom_range(0, 19) == 0);
        if (dl) begin
          idl = NP'($urandom);
          blk = ~idl | NP'($urandom);
          blk[1] = 1'($urandom);
          ax  = NA'($urandom_range(1, 3));
          ch  = ($urandom_range(0, 9) != 0);
        end else begin
          idl = NP'($urandom); blk = NP'($urandom);
          ax = NA'($urandom); ch = 1'($urandom);
        end
        drive(idl, blk, ax, ch, clr);
      end
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/deadlock_df_monitor.md
# deadlock_df_monitor

Parametrised dataflow deadlock monitor for HLS dataflow regions in the ADC capture path. It generalises the fixed three-process, two-stream monitor to NPROC processes and NAXIS AXI-Stream channels. A deadlock must persist for HOLD_CYCLES consecutive cycles before it is reported. Each region gets one instance; the `child_block` input chains it to the monitor of a nested region.

## Interface
Parameters:
- NPROC, 3, number of dataflow processes (≥1)
- NAXIS, 2, number of monitored AXI-Stream channels (≥1)
- AXIS_PROC_MASK, 3'b010, NPROC-bit mask; bit i set = process i can be AXIS-blocked
- HOLD_CYCLES, 4, consecutive stop cycles required before `block` (≥1)
- CNT_W, 8, width of event counter and hold counter

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear  in  1  synchronous clear of sticky state and event counter
- axis_block_sigs  in  NAXIS  per-channel stream blocked
- inst_idle_sigs  in  NPROC  per-process idle
- inst_block_sigs  in  NPROC  per-process blocked on internal channel
- child_block  in  1  `block` of the nested region monitor; tie 1 if none
- block  out  1  deadlock currently confirmed
- block_latched  out  1  sticky; a deadlock was confirmed since reset/clear
- axis_block_info  out  NAXIS  registered axis_block_sigs, gated to 0 unless `block`
- event_count  out  CNT_W  saturating count of confirmed deadlock entries
- snap_axis  out  NAXIS  snapshot (see Configuration)
- snap_stop  out  NPROC  snapshot (see Configuration)

## Operation
- Combinational per process i:
  - pab[i] = AXIS_PROC_MASK[i] & child_block & |axis_block_sigs
  - stop[i] = inst_idle_sigs[i] | inst_block_sigs[i] | pab[i]
- cond = (|pab) & (&stop).
- FSM states: MON_IDLE, MON_COUNT, MON_BLOCK. Hold counter `hcnt` is internal.
  - MON_IDLE: cond=1 and HOLD_CYCLES=1 → MON_BLOCK. cond=1 and HOLD_CYCLES>1 → MON_COUNT with hcnt=1.
  - MON_COUNT: cond=0 → MON_IDLE, hcnt=0. cond=1 and hcnt==HOLD_CYCLES-1 → MON_BLOCK. Otherwise hcnt++.
  - MON_BLOCK: cond=0 → MON_IDLE. Otherwise stay.
- `block` = (state==MON_BLOCK), driven from a register.
- Entry into MON_BLOCK (the transition edge):
  - set block_latched
  - event_count++, saturating at 2^CNT_W-1
- axis_block_info: internal register loads axis_block_sigs every cycle. The output is that register ANDed with {NAXIS{block}}.
- clear: zeroes block_latched, event_count and the snapshots. FSM and hcnt are unaffected.
- clear coincident with entry into MON_BLOCK: the entry wins. block_latched=1, event_count=1, snapshot captured.
- reset: all state to zero (FSM MON_IDLE, hcnt 0). It takes priority over everything.
- Parameter check: HOLD_CYCLES ≥ 2^CNT_W is illegal; it is flagged by an elaboration-time error.

## Timing
- Reset values: block=0, block_latched=0, axis_block_info=0, event_count=0, snap_axis=0, snap_stop=0.
- cond first true at edge k, held true → block=1 after edge k+HOLD_CYCLES-1, visible in cycle k+HOLD_CYCLES. With HOLD_CYCLES=1 this is one cycle of latency.
- cond falling at edge j → block=0 after edge j.
- axis_block_info is aligned with the registered sigs of the same edge that updates block.
- A one-cycle drop of cond during MON_COUNT restarts the hold window in full.
- Chained monitors add one cycle per level through child_block.

## Configuration
- DEADLOCK_MON_SNAPSHOT_EN defined: on MON_BLOCK entry, snap_axis ← axis_block_sigs and snap_stop ← {inst_block_sigs}. They hold until clear or reset and are not overwritten by later entries until cleared.
- Not defined: no snapshot registers; snap_axis and snap_stop are tied to 0.

## Test plan
- Defaults, HOLD_CYCLES=4: inst_idle=3'b101, axis_block=2'b01, child_block=1 held → block=1 in 5th cycle; axis_block_info=2'b01; event_count=1; block_latched=1.
- Same stimulus, but cond drops for 1 cycle after 3 cycles, then resumes → block rises 4 cycles after resume, not before.
- child_block=0, everything else stopped → block stays 0 indefinitely; event_count=0.
- Deadlock entered, released, re-entered 3 times → event_count=3; block_latched=1. Then assert clear → block_latched=0, event_count=0.
- CNT_W=2, 5 entries → event_count saturates at 3.
- Macro on: entry with inst_block=3'b101, axis=2'b10 → snap_stop=3'b101, snap_axis=2'b10, unchanged by a second entry with different values. Macro off → both remain 0.
